// File: rtl/ysyx_24110006_writeback_unit.sv
// Writeback stage: round-robin pick of the ALU/LSU result, one register-file write per
// instruction, then a commit pulse once the register file acknowledges.
module ysyx_24110006_writeback_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_alu_valid,
   output logic                  o_alu_ready,
   input  logic [ADDR_WIDTH-1:0] i_alu_rd,
   input  logic                  i_alu_wen,
   input  logic [DATA_WIDTH-1:0] i_alu_data,
   input  logic [DATA_WIDTH-1:0] i_alu_pc,
   input  logic                  i_lsu_valid,
   output logic                  o_lsu_ready,
   input  logic [ADDR_WIDTH-1:0] i_lsu_rd,
   input  logic                  i_lsu_wen,
   input  logic [DATA_WIDTH-1:0] i_lsu_data,
   input  logic [DATA_WIDTH-1:0] i_lsu_pc,
   output logic                  o_rf_valid,
   output logic                  o_rf_wen,
   output logic [ADDR_WIDTH-1:0] o_rf_waddr,
   output logic [DATA_WIDTH-1:0] o_rf_wdata,
   input  logic                  i_rf_valid,
   output logic                  o_commit,
   output logic [DATA_WIDTH-1:0] o_commit_pc,
   output logic [CNT_WIDTH-1:0]  o_commit_cnt,
   output logic                  o_err,
   output logic [1:0]            o_dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                  wen_q, wen_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  err_q, err_d;
   logic                  commit_q, commit_d;
   logic [DATA_WIDTH-1:0] commit_pc_q, commit_pc_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic grant_lsu;
   logic alu_ready;
   logic lsu_ready;
   logic handshake;

   // A channel transfers on a cycle where its valid and ready are both high; ready depends
   // only on state, last and the two valids, and a producer may drop valid while ready is 0.
   always_comb begin
      grant_lsu = i_lsu_valid && (!i_alu_valid || !last_q);
      alu_ready = (state_q == ST_IDLE) && i_reset && !grant_lsu;
      lsu_ready = (state_q == ST_IDLE) && i_reset && grant_lsu;
      handshake = (i_alu_valid && alu_ready) || (i_lsu_valid && lsu_ready);
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      rd_d        = rd_q;
      wen_d       = wen_q;
      data_d      = data_q;
      pc_d        = pc_q;
      err_d       = err_q;
      commit_d    = 1'b0;
      commit_pc_d = commit_pc_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               state_d = ST_WRITE;
               last_d  = grant_lsu;
               rd_d    = grant_lsu ? i_lsu_rd   : i_alu_rd;
               wen_d   = grant_lsu ? i_lsu_wen  : i_alu_wen;
               data_d  = grant_lsu ? i_lsu_data : i_alu_data;
               pc_d    = grant_lsu ? i_lsu_pc   : i_alu_pc;
            end
         end
         ST_WRITE: begin
            state_d = ST_WAIT;
            // Upper half of the index space does not exist in RV32E; flag it but still write.
            if (wen_q && rd_q[ADDR_WIDTH-1]) begin
               err_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (i_rf_valid) begin
               state_d     = ST_IDLE;
               commit_d    = 1'b1;
               commit_pc_d = pc_q;
               cnt_d       = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         rd_q        <= '0;
         wen_q       <= 1'b0;
         data_q      <= '0;
         pc_q        <= '0;
         err_q       <= 1'b0;
         commit_q    <= 1'b0;
         commit_pc_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         rd_q        <= rd_d;
         wen_q       <= wen_d;
         data_q      <= data_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
         commit_q    <= commit_d;
         commit_pc_q <= commit_pc_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_alu_ready  = alu_ready;
   assign o_lsu_ready  = lsu_ready;
   assign o_rf_valid   = (state_q == ST_WRITE);
   // x0 is hardwired to zero, so its write is dropped while the instruction still retires.
   assign o_rf_wen     = (state_q == ST_WRITE) && wen_q && (rd_q != '0);
   assign o_rf_waddr   = rd_q;
   assign o_rf_wdata   = data_q;
   assign o_commit     = commit_q;
   assign o_commit_pc  = commit_pc_q;
   assign o_commit_cnt = cnt_q;
   assign o_err        = err_q;
   assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_ysyx_24110006_writeback_unit.sv
// Bench for the writeback unit: channel drivers, a register-file ack model, and monitors
// that pop expected writes/commits from queues filled when stimulus is issued.
module tb_ysyx_24110006_writeback_unit;

   typedef struct packed {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
      logic [31:0] pc;
   } item_t;

   logic        i_clock;
   logic        i_reset;
   logic        i_alu_valid, o_alu_ready, i_alu_wen;
   logic [4:0]  i_alu_rd;
   logic [31:0] i_alu_data, i_alu_pc;
   logic        i_lsu_valid, o_lsu_ready, i_lsu_wen;
   logic [4:0]  i_lsu_rd;
   logic [31:0] i_lsu_data, i_lsu_pc;
   logic        o_rf_valid, o_rf_wen;
   logic [4:0]  o_rf_waddr;
   logic [31:0] o_rf_wdata;
   logic        i_rf_valid;
   logic        o_commit;
   logic [31:0] o_commit_pc;
   logic [31:0] o_commit_cnt;
   logic        o_err;
   logic [1:0]  o_dbg_state;

   ysyx_24110006_writeback_unit #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(32)
   ) dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_rd(i_alu_rd),
      .i_alu_wen(i_alu_wen), .i_alu_data(i_alu_data), .i_alu_pc(i_alu_pc),
      .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_rd(i_lsu_rd),
      .i_lsu_wen(i_lsu_wen), .i_lsu_data(i_lsu_data), .i_lsu_pc(i_lsu_pc),
      .o_rf_valid(o_rf_valid), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
      .o_rf_wdata(o_rf_wdata), .i_rf_valid(i_rf_valid),
      .o_commit(o_commit), .o_commit_pc(o_commit_pc), .o_commit_cnt(o_commit_cnt),
      .o_err(o_err), .o_dbg_state(o_dbg_state)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ack_delay = 0;
   bit ack_en    = 1'b1;
   bit alu_fired = 1'b0;
   bit lsu_fired = 1'b0;

   item_t       alu_src_q[$];
   item_t       lsu_src_q[$];
   logic [37:0] wr_exp_q[$];   // {wen, waddr, wdata}
   logic [71:0] cm_exp_q[$];   // {latency, pc, cnt}
   int          hs_cyc_q[$];
   int          commit_cyc[$];

   // ---------------- clock / reset ----------------
   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge i_clock);
      i_reset = 1'b0;
      hs_cyc_q.delete();
      repeat (2) @(negedge i_clock);
      check("reset_alu_ready", 64'(o_alu_ready), 64'd0);
      check("reset_lsu_ready", 64'(o_lsu_ready), 64'd0);
      i_reset = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_alu(input logic [4:0] rd, input logic wen, input logic [31:0] d,
                           input logic [31:0] pc);
      alu_src_q.push_back('{rd: rd, wen: wen, data: d, pc: pc});
   endtask

   task automatic push_lsu(input logic [4:0] rd, input logic wen, input logic [31:0] d,
                           input logic [31:0] pc);
      lsu_src_q.push_back('{rd: rd, wen: wen, data: d, pc: pc});
   endtask

   task automatic expect_wr(input logic wen, input logic [4:0] rd, input logic [31:0] d);
      wr_exp_q.push_back({wen, rd, d});
   endtask

   task automatic expect_cm(input logic [7:0] lat, input logic [31:0] pc, input logic [31:0] cnt);
      cm_exp_q.push_back({lat, pc, cnt});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((wr_exp_q.size() != 0 || cm_exp_q.size() != 0 || alu_src_q.size() != 0 ||
              lsu_src_q.size() != 0) && n < 300) begin
         @(negedge i_clock);
         n++;
      end
      total++;
      if (n >= 300) begin
         bad++;
         $display("FAIL %s_drain: actual=timeout required=all expected events seen", name);
         wr_exp_q.delete();
         cm_exp_q.delete();
      end
   endtask

   initial begin : alu_driver
      item_t it;
      i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_wen = 1'b0; i_alu_data = '0; i_alu_pc = '0;
      forever begin
         @(posedge i_clock);
         #1;
         if (i_alu_valid && alu_fired) i_alu_valid = 1'b0;
         if (!i_alu_valid && alu_src_q.size() > 0) begin
            it = alu_src_q.pop_front();
            i_alu_rd = it.rd; i_alu_wen = it.wen; i_alu_data = it.data; i_alu_pc = it.pc;
            i_alu_valid = 1'b1;
         end
      end
   end

   initial begin : lsu_driver
      item_t it;
      i_lsu_valid = 1'b0; i_lsu_rd = '0; i_lsu_wen = 1'b0; i_lsu_data = '0; i_lsu_pc = '0;
      forever begin
         @(posedge i_clock);
         #1;
         if (i_lsu_valid && lsu_fired) i_lsu_valid = 1'b0;
         if (!i_lsu_valid && lsu_src_q.size() > 0) begin
            it = lsu_src_q.pop_front();
            i_lsu_rd = it.rd; i_lsu_wen = it.wen; i_lsu_data = it.data; i_lsu_pc = it.pc;
            i_lsu_valid = 1'b1;
         end
      end
   end

   // Register file: acknowledge one cycle after the write, plus ack_delay extra cycles.
   initial begin : rf_model
      i_rf_valid = 1'b0;
      forever begin
         @(negedge i_clock);
         if (o_rf_valid === 1'b1 && ack_en) begin
            repeat (ack_delay) @(negedge i_clock);
            @(negedge i_clock);
            i_rf_valid = 1'b1;
            @(negedge i_clock);
            i_rf_valid = 1'b0;
         end
      end
   end

   // ---------------- monitors / scoreboard ----------------
   initial begin : mon_hs
      forever begin
         @(negedge i_clock);
         alu_fired = (i_alu_valid === 1'b1) && (o_alu_ready === 1'b1);
         lsu_fired = (i_lsu_valid === 1'b1) && (o_lsu_ready === 1'b1);
         if (alu_fired || lsu_fired) hs_cyc_q.push_back(cyc);
      end
   end

   initial begin : mon_wr
      logic [37:0] e;
      forever begin
         @(negedge i_clock);
         if (o_rf_valid === 1'b1) begin
            if (wr_exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write: actual waddr=%0d wdata=%0h required=no write",
                        o_rf_waddr, o_rf_wdata);
            end else begin
               e = wr_exp_q.pop_front();
               check("rf_write", 64'({o_rf_wen, o_rf_waddr, o_rf_wdata}), 64'(e));
            end
         end
      end
   end

   initial begin : mon_cm
      logic [71:0] e;
      int          h;
      forever begin
         @(negedge i_clock);
         if (o_commit === 1'b1) begin
            commit_cyc.push_back(cyc);
            if (cm_exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_commit: actual pc=%0h cnt=%0d required=no commit",
                        o_commit_pc, o_commit_cnt);
            end else begin
               e = cm_exp_q.pop_front();
               check("commit_pc", 64'(o_commit_pc), 64'(e[63:32]));
               check("commit_cnt", 64'(o_commit_cnt), 64'(e[31:0]));
               h = (hs_cyc_q.size() > 0) ? hs_cyc_q.pop_front() : -1000;
               check("commit_latency", 64'(cyc - h), 64'(e[71:64]));
            end
         end
      end
   end

   // ---------------- directed tests ----------------
   initial begin : main
      int n;
      i_reset = 1'b0;
      do_reset();
      check("rst_state", 64'(o_dbg_state), 64'd0);
      check("rst_rf_valid", 64'(o_rf_valid), 64'd0);
      check("rst_rf_wen", 64'(o_rf_wen), 64'd0);
      check("rst_commit", 64'(o_commit), 64'd0);
      check("rst_commit_pc", 64'(o_commit_pc), 64'd0);
      check("rst_commit_cnt", 64'(o_commit_cnt), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);

      // ALU only
      push_alu(5'd5, 1'b1, 32'hDEADBEEF, 32'h8000_0000);
      expect_wr(1'b1, 5'd5, 32'hDEADBEEF);
      expect_cm(8'd3, 32'h8000_0000, 32'd1);
      wait_drain("alu_only");
      repeat (3) @(negedge i_clock);
      check("commit_pc_held", 64'(o_commit_pc), 64'h8000_0000);
      check("commit_low_after_pulse", 64'(o_commit), 64'd0);

      // Tie fairness after reset
      do_reset();
      commit_cyc.delete();
      push_alu(5'd1, 1'b1, 32'h11, 32'h100);
      push_alu(5'd3, 1'b1, 32'h33, 32'h108);
      push_lsu(5'd2, 1'b1, 32'h22, 32'h104);
      push_lsu(5'd4, 1'b1, 32'h44, 32'h10C);
      expect_wr(1'b1, 5'd1, 32'h11); expect_cm(8'd3, 32'h100, 32'd1);
      expect_wr(1'b1, 5'd2, 32'h22); expect_cm(8'd3, 32'h104, 32'd2);
      expect_wr(1'b1, 5'd3, 32'h33); expect_cm(8'd3, 32'h108, 32'd3);
      expect_wr(1'b1, 5'd4, 32'h44); expect_cm(8'd3, 32'h10C, 32'd4);
      wait_drain("tie");
      check("tie_cnt", 64'(o_commit_cnt), 64'd4);
      check("tie_commit_count", 64'(commit_cyc.size()), 64'd4);
      for (int i = 1; i < commit_cyc.size(); i++)
         check("tie_commit_spacing", 64'(commit_cyc[i] - commit_cyc[i-1]), 64'd3);

      // x0 write: suppressed enable, still retires
      push_lsu(5'd0, 1'b1, 32'h1234, 32'h200);
      expect_wr(1'b0, 5'd0, 32'h1234);
      expect_cm(8'd3, 32'h200, 32'd5);
      wait_drain("x0");

      // Delayed ack with both producers waiting
      ack_delay = 5;
      push_alu(5'd7, 1'b1, 32'hCAFEF00D, 32'h300);
      push_lsu(5'd8, 1'b1, 32'h5555AAAA, 32'h304);
      expect_wr(1'b1, 5'd7, 32'hCAFEF00D); expect_cm(8'd8, 32'h300, 32'd6);
      expect_wr(1'b1, 5'd8, 32'h5555AAAA); expect_cm(8'd8, 32'h304, 32'd7);
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (o_rf_valid !== 1'b1 && n < 50);
      check("delay_write_seen", 64'(o_rf_valid), 64'd1);
      repeat (5) begin
         @(negedge i_clock);
         check("delay_alu_ready", 64'(o_alu_ready), 64'd0);
         check("delay_lsu_ready", 64'(o_lsu_ready), 64'd0);
         check("delay_no_commit", 64'(o_commit), 64'd0);
      end
      wait_drain("delayed_ack");
      ack_delay = 0;

      // Reset while waiting for the ack
      ack_en = 1'b0;
      push_alu(5'd9, 1'b1, 32'h99, 32'h400);
      expect_wr(1'b1, 5'd9, 32'h99);
      n = 0;
      do begin
         @(negedge i_clock);
         n++;
      end while (o_rf_valid !== 1'b1 && n < 50);
      @(negedge i_clock);
      check("wait_state", 64'(o_dbg_state), 64'd2);
      do_reset();
      check("abort_state", 64'(o_dbg_state), 64'd0);
      check("abort_commit", 64'(o_commit), 64'd0);
      check("abort_cnt", 64'(o_commit_cnt), 64'd0);
      ack_en = 1'b1;
      push_alu(5'd10, 1'b1, 32'hA0, 32'h500);
      push_lsu(5'd11, 1'b1, 32'hB0, 32'h504);
      expect_wr(1'b1, 5'd10, 32'hA0); expect_cm(8'd3, 32'h500, 32'd1);
      expect_wr(1'b1, 5'd11, 32'hB0); expect_cm(8'd3, 32'h504, 32'd2);
      wait_drain("tie_after_abort");

      // Illegal index sets a sticky error
      check("err_before", 64'(o_err), 64'd0);
      push_alu(5'd17, 1'b1, 32'h77, 32'h600);
      expect_wr(1'b1, 5'd17, 32'h77);
      expect_cm(8'd3, 32'h600, 32'd3);
      wait_drain("illegal");
      check("err_set", 64'(o_err), 64'd1);
      push_lsu(5'd3, 1'b1, 32'h3, 32'h604);
      expect_wr(1'b1, 5'd3, 32'h3);
      expect_cm(8'd3, 32'h604, 32'd4);
      wait_drain("legal_after_err");
      check("err_sticky", 64'(o_err), 64'd1);
      do_reset();
      check("err_cleared", 64'(o_err), 64'd0);

      repeat (3) @(negedge i_clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_24110006_writeback_unit.md
# ysyx_24110006_writeback_unit

Writeback stage that arbitrates completed results from the ALU and LSU channels and drives the write port of the register file (`wdata/waddr/wen/valid`). It consumes the register file's one-cycle `valid` acknowledge to close each transaction. On every completed writeback it emits a commit pulse with the retiring PC and keeps a retired-instruction counter for difftest and perf reporting. The unit handles one transaction at a time, three cycles per instruction.

## Interface
- `ADDR_WIDTH`, 5, register index width.
- `DATA_WIDTH`, 32, data and PC width.
- `CNT_WIDTH`, 32, retired-instruction counter width.

- `i_clock`  in  1  sole clock; all state updates on posedge.
- `i_reset`  in  1  synchronous, active-low reset (0 = reset).
- `i_alu_valid`  in  1  ALU result offered.
- `o_alu_ready`  out  1  ALU result accepted this cycle if valid.
- `i_alu_rd`  in  ADDR_WIDTH  destination register.
- `i_alu_wen`  in  1  instruction writes rd.
- `i_alu_data`  in  DATA_WIDTH  result value.
- `i_alu_pc`  in  DATA_WIDTH  instruction PC.
- `i_lsu_valid`, `o_lsu_ready`, `i_lsu_rd`, `i_lsu_wen`, `i_lsu_data`, `i_lsu_pc`: same widths and meanings for the LSU channel.
- `o_rf_valid`  out  1  writeback request to the register file.
- `o_rf_wen`  out  1  register write enable.
- `o_rf_waddr`  out  ADDR_WIDTH  write index.
- `o_rf_wdata`  out  DATA_WIDTH  write data.
- `i_rf_valid`  in  1  register file acknowledge, high one cycle after an accepted `o_rf_valid`.
- `o_commit`  out  1  one-cycle retire pulse.
- `o_commit_pc`  out  DATA_WIDTH  PC of the retired instruction; held until the next retire.
- `o_commit_cnt`  out  CNT_WIDTH  number of instructions retired since reset.
- `o_err`  out  1  sticky flag: a write targeted rd[4]=1 (index not implemented in RV32E).

## Operation
- States: IDLE, WRITE, WAIT.
- IDLE
  - Ready is asserted toward exactly one channel chosen by the arbiter; the other channel's ready is 0.
  - Handshake occurs when valid && ready. On a handshake, rd, wen, data, and pc are captured into holding registers and the state moves to WRITE.
  - No valid input: remain in IDLE.
- Arbiter
  - Round-robin with a `last` bit (0 = ALU was last granted).
  - Only one channel valid: that channel is granted.
  - Both valid: the channel not granted last is selected.
  - After reset `last` = 1, so the ALU wins the first tie.
  - `last` updates only on a handshake.
- WRITE
  - `o_rf_valid` = 1 for exactly one cycle.
  - `o_rf_wen` = held_wen && held_rd != 0. Writes to x0 are suppressed, but the transaction still retires.
  - `o_rf_waddr` and `o_rf_wdata` carry the held values.
  - Next state is WAIT unconditionally.
  - If held_wen && held_rd[4], set `o_err` (sticky until reset). The write is still issued with the full index.
- WAIT
  - Stay until `i_rf_valid` = 1.
  - On that edge: go to IDLE, `o_commit` <= 1, `o_commit_pc` <= held_pc, `o_commit_cnt` <= cnt + 1 (wraps modulo 2^CNT_WIDTH).
  - No timeout: WAIT holds indefinitely.
- `o_commit` is cleared on the following edge unless another retire occurs. Back-to-back retires are impossible, so the pulse is always exactly one cycle.
- Outside WRITE, `o_rf_valid` = 0 and `o_rf_wen` = 0. `o_rf_waddr` and `o_rf_wdata` keep their held values (don't-care to the register file).
- `i_rf_valid` arriving in IDLE or WRITE is ignored.

## Timing
- Reset (`i_reset` = 0 at a posedge): state = IDLE, `last` = 1, holding registers = 0.
- Output values in reset: `o_rf_valid`/`o_rf_wen` = 0, `o_commit` = 0, `o_commit_pc` = 0, `o_commit_cnt` = 0, `o_err` = 0.
- Ready outputs are 0 while `i_reset` = 0. Ready is combinational from state, `last`, and the valids, with no combinational path from data inputs.
- Reset mid-transaction (in WRITE or WAIT) abandons the instruction: no commit, counter not incremented.
- Latency, with the handshake at edge E0:
  - Cycle after E0: `o_rf_valid` = 1. The register file writes at E1.
  - Between E1 and E2: `i_rf_valid` = 1.
  - After E2: `o_commit` = 1 and ready is available again.
- Sustained throughput is one instruction per 3 cycles.
- A producer whose valid drops while ready = 0 is legal; nothing is captured for it.

## Test plan
- ALU only: `i_alu_valid`=1, rd=5, wen=1, data=0xDEADBEEF, pc=0x80000000. Required: `o_rf_valid`/`o_rf_wen` high one cycle later with waddr=5 and wdata=0xDEADBEEF; `o_commit`=1 with `o_commit_pc`=0x80000000 three cycles after the handshake; `o_commit_cnt`=1.
- Tie fairness: both channels valid continuously for 4 transactions after reset. Required: grant order ALU, LSU, ALU, LSU; `o_commit_cnt`=4; commit pulses exactly 3 cycles apart.
- x0 write: LSU rd=0, wen=1, data=0x1234. Required: `o_rf_valid`=1 with `o_rf_wen`=0; commit still pulses; counter increments.
- Delayed ack: hold `i_rf_valid`=0 for 5 cycles after WRITE. Required: both readys stay 0; no commit; commit occurs the cycle after `i_rf_valid` rises.
- Reset in WAIT: assert `i_reset`=0 while in WAIT. Required: no commit, `o_commit_cnt`=0, IDLE afterwards; the next tie grants ALU.
- Illegal index: ALU rd=17, wen=1. Required: `o_err` rises and stays 1 through later legal writes until reset.
